// File: rtl/cic_comb_decimator.sv
// CIC decimator back end: keeps every R-th integrator sample and runs it through N comb stages.
// Optional macro CIC_COMB_ROUND_EN adds a round-half-up/saturate output stage (latency N+2).
module cic_comb_decimator #(
  parameter int DATA_WIDTH_INP = 16,
  parameter int DATA_WIDTH_OUT = 16,
  parameter int DECIMATION     = 4,
  parameter int STAGES         = 3,
  parameter int DIFF_DELAY     = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic signed [DATA_WIDTH_INP-1:0] inp_samp_data,
  input  logic                             inp_samp_str,
  output logic signed [DATA_WIDTH_OUT-1:0] out_samp_data,
  output logic                             out_samp_str
);

  localparam int CNT_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam logic [CNT_W-1:0] LAST_PHASE = CNT_W'(DECIMATION - 1);
  localparam int SHIFT = DATA_WIDTH_INP - DATA_WIDTH_OUT;

  logic [CNT_W-1:0]                 phase;
  logic signed [DATA_WIDTH_INP-1:0] dec_data;
  logic                             dec_str;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= '0;
      dec_data <= '0;
      dec_str  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      dec_str <= 1'b0;
      if (inp_samp_str) begin
        if (phase == LAST_PHASE) begin
          phase    <= '0;
          dec_data <= inp_samp_data;
          dec_str  <= 1'b1;
        end else begin
          phase <= phase + CNT_W'(1);
        end
      end
    end
  end

  logic signed [DATA_WIDTH_INP-1:0] comb_data     [STAGES];
  logic                             comb_str      [STAGES];
  logic signed [DATA_WIDTH_INP-1:0] dly           [STAGES][DIFF_DELAY];
  logic signed [DATA_WIDTH_INP-1:0] stage_in_data [STAGES];
  logic                             stage_in_str  [STAGES];

  always_comb begin
    // NOTE: every element is assigned on every evaluation, so no latch can be inferred.
    stage_in_data[0] = dec_data;
    stage_in_str[0]  = dec_str;
    for (int k = 1; k < STAGES; k++) begin
      stage_in_data[k] = comb_data[k-1];
      stage_in_str[k]  = comb_str[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the delay lines are reset as well; the first M outputs of each stage rely on a zero history.
      for (int k = 0; k < STAGES; k++) begin
        comb_data[k] <= '0;
        comb_str[k]  <= 1'b0;
        for (int m = 0; m < DIFF_DELAY; m++) dly[k][m] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        comb_str[k] <= stage_in_str[k];
        if (stage_in_str[k]) begin
          // Modular subtraction: wrap-around is what keeps the integrator/comb pair exact.
          comb_data[k] <= stage_in_data[k] - dly[k][DIFF_DELAY-1];
          dly[k][0]    <= stage_in_data[k];
          for (int m = 1; m < DIFF_DELAY; m++) dly[k][m] <= dly[k][m-1];
        end
      end
    end
  end

  logic signed [DATA_WIDTH_INP-1:0] comb_last;
  logic                             comb_last_str;

  assign comb_last     = comb_data[STAGES-1];
  assign comb_last_str = comb_str[STAGES-1];

`ifdef CIC_COMB_ROUND_EN
  logic signed [DATA_WIDTH_OUT-1:0] rounded;
  logic signed [DATA_WIDTH_OUT-1:0] rnd_data;
  logic                             rnd_str;

  if (SHIFT == 0) begin : g_pass
    assign rounded = comb_last;
  end else begin : g_round
    localparam logic [DATA_WIDTH_INP-1:0] HALF = DATA_WIDTH_INP'(1) << (SHIFT - 1);
    logic [DATA_WIDTH_INP-1:0] sum;
    logic                      unused_sum_lsbs;

    assign sum             = comb_last + HALF;
    assign unused_sum_lsbs = ^sum[SHIFT-1:0];
    // Only a non-negative value can carry into the sign bit; clamp it to the largest positive code.
    assign rounded = (!comb_last[DATA_WIDTH_INP-1] && sum[DATA_WIDTH_INP-1])
                   ? {1'b0, {(DATA_WIDTH_OUT-1){1'b1}}}
                   : sum[DATA_WIDTH_INP-1 -: DATA_WIDTH_OUT];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rnd_data      <= '0;
      rnd_str       <= 1'b0;
      out_samp_data <= '0;
      out_samp_str  <= 1'b0;
    end else begin
      rnd_str      <= comb_last_str;
      out_samp_str <= rnd_str;
      if (comb_last_str) rnd_data <= rounded;
      if (rnd_str) out_samp_data <= rnd_data;
    end
  end
`else
  if (SHIFT > 0) begin : g_trunc
    logic unused_lsbs;
    assign unused_lsbs = ^comb_last[SHIFT-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_samp_data <= '0;
      out_samp_str  <= 1'b0;
    end else begin
      out_samp_str <= comb_last_str;
      if (comb_last_str) out_samp_data <= comb_last[DATA_WIDTH_INP-1 -: DATA_WIDTH_OUT];
    end
  end
`endif

endmodule

// File: tb/tb_cic_comb_decimator.sv
// Self-checking bench for cic_comb_decimator: five configurations, each against a binomial-sum model
// plus hand-computed pinned outputs. Honours CIC_COMB_ROUND_EN when defined.
`timescale 1ns/1ps
module tb_cic_comb_decimator;

  localparam int NCFG = 5;
  localparam int P_IW    [NCFG] = '{16, 16, 8, 16, 16};
  localparam int P_OW    [NCFG] = '{16, 16, 8, 16, 12};
  localparam int P_R     [NCFG] = '{1, 4, 1, 2, 1};
  localparam int P_N     [NCFG] = '{3, 1, 1, 1, 1};
  localparam int P_M     [NCFG] = '{1, 1, 1, 2, 1};
  localparam int P_PINS  [NCFG] = '{5, 4, 2, 4, 4};
  localparam int P_TOTAL [NCFG] = '{8, 4, 2, 6, 4};
  localparam int P_LAT   [NCFG] = '{4, 2, 2, 2, 2};
  localparam int P_GAP   [NCFG] = '{1, 4, 1, 6, 1};
`ifdef CIC_COMB_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [NCFG];
  logic        in_str  [NCFG];
  logic [15:0] in_data [NCFG];
  bit          done = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Hand-computed output sequences for the directed stimulus below.
  function automatic longint pin_val(input int c, input int k);
    case (c)
      0: case (k)
           0: return 1;
           1: return -3;
           2: return 3;
           3: return -1;
           default: return 0;
         endcase
      1: case (k)
           0: return 15;
           1: return 20;
           2: return 20;
           default: return 600;
         endcase
      2: return (k == 0) ? 120 : 10;
      3: case (k)
           0: return -23;
           1: return -9;
           default: return 28;
         endcase
      default: case (k)
           0: return ROUND ? 2 : 1;
           1: return 2047;
           2: return ROUND ? -2 : -3;
           default: return ROUND ? 1 : 0;
         endcase
    endcase
  endfunction

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int IW      = P_IW[gi];
    localparam int OW      = P_OW[gi];
    localparam int R       = P_R[gi];
    localparam int N       = P_N[gi];
    localparam int M       = P_M[gi];
    localparam int LAT     = N + 1 + int'(ROUND);
    localparam int HALF_SH = (IW > OW) ? IW - OW - 1 : 0;

    logic signed [IW-1:0] din;
    logic signed [OW-1:0] dout;
    logic                 dstr;

    assign din = in_data[gi][IW-1:0];

    cic_comb_decimator #(
      .DATA_WIDTH_INP(IW),
      .DATA_WIDTH_OUT(OW),
      .DECIMATION    (R),
      .STAGES        (N),
      .DIFF_DELAY    (M)
    ) dut (
      .clk          (clk),
      .reset        (rst[gi]),
      .inp_samp_data(din),
      .inp_samp_str (in_str[gi]),
      .out_samp_data(dout),
      .out_samp_str (dstr)
    );

    int     ecnt = 0;
    int     phase = 0;
    bit     armed = 1'b0;
    int     first_kept = -1;
    int     first_out = -1;
    int     got = 0;
    longint last = 0;
    longint hist     [$];
    int     exp_edge [$];
    longint exp_val  [$];

    // Model: y[n] = sum_j (-1)^j C(N,j) x[n-jM] over kept samples, wrapped to IW bits, then scaled.
    always @(posedge clk) begin : model
      longint acc, c, s, modv, y;
      int     n;
      ecnt++;
      if (rst[gi]) begin
        armed = 1'b1;
        phase = 0;
        last  = 0;
        hist.delete();
        exp_edge.delete();
        exp_val.delete();
      end else if (in_str[gi]) begin
        phase++;
        if (phase == R) begin
          phase = 0;
          hist.push_back(longint'(din));
          if (first_kept < 0) first_kept = ecnt;
          n   = hist.size() - 1;
          acc = 0;
          c   = 1;
          for (int j = 0; j <= N; j++) begin
            if (n - j * M >= 0) acc += (((j % 2) != 0) ? -c : c) * hist[n - j * M];
            c = c * (N - j) / (j + 1);
          end
          modv = longint'(1) << IW;
          acc  = acc % modv;
          if (acc < 0) acc += modv;
          if (acc >= modv / 2) acc -= modv;
          if (ROUND && IW > OW) begin
            s = acc + (longint'(1) << HALF_SH);
            y = (s > modv / 2 - 1) ? (longint'(1) << (OW - 1)) - 1 : (s >>> (IW - OW));
          end else begin
            y = acc >>> (IW - OW);
          end
          exp_edge.push_back(ecnt + LAT);
          exp_val.push_back(y);
        end
      end
    end

    always @(negedge clk) begin : compare
      bit want;
      if (armed) begin
        want = (exp_edge.size() > 0) && (exp_edge[0] == ecnt);
        check(dstr === want, $sformatf("cfg%0d strobe edge%0d", gi, ecnt), longint'(dstr), longint'(want));
        if (want) begin
          last = exp_val[0];
          exp_val.pop_front();
          exp_edge.pop_front();
        end
        check(longint'(dout) == last, $sformatf("cfg%0d data edge%0d", gi, ecnt), longint'(dout), last);
        if (dstr === 1'b1) begin
          if (got < P_PINS[gi])
            check(longint'(dout) == pin_val(gi, got), $sformatf("cfg%0d pinned out%0d", gi, got),
                  longint'(dout), pin_val(gi, got));
          if (got == 0)
            check(ecnt - first_kept == P_LAT[gi] + int'(ROUND), $sformatf("cfg%0d latency", gi),
                  longint'(ecnt - first_kept), longint'(P_LAT[gi] + int'(ROUND)));
          if (got == 1)
            check(ecnt - first_out == P_GAP[gi], $sformatf("cfg%0d strobe gap", gi),
                  longint'(ecnt - first_out), longint'(P_GAP[gi]));
          if (got == 0) first_out = ecnt;
          got++;
        end
      end
    end

    always @(posedge done) begin
      check(got == P_TOTAL[gi], $sformatf("cfg%0d output count", gi), longint'(got), longint'(P_TOTAL[gi]));
      check(exp_edge.size() == 0, $sformatf("cfg%0d pending outputs", gi), longint'(exp_edge.size()), 0);
    end
  end

  task automatic drive(input int c, input logic [15:0] d, input logic s);
    @(negedge clk);
    in_data[c] = d;
    in_str[c]  = s;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int c = 0; c < NCFG; c++) begin
      rst[c]     = 1'b1;
      in_str[c]  = 1'b0;
      in_data[c] = '0;
    end
    idle(2);
    for (int c = 0; c < NCFG; c++) rst[c] = 1'b0;
    idle(3);

    // Impulse through three combs, R=1.
    drive(0, 16'd1, 1'b1);
    for (int k = 0; k < 7; k++) drive(0, 16'd0, 1'b1);
    drive(0, 16'd0, 1'b0);
    idle(10);

    // Ramp with R=4, then a partial phase interrupted by reset.
    for (int k = 0; k < 12; k++) drive(1, 16'(k * 5), 1'b1);
    drive(1, 16'd0, 1'b0);
    drive(1, 16'd100, 1'b1);
    drive(1, 16'd200, 1'b1);
    @(negedge clk);
    rst[1]    = 1'b1;
    in_str[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b0;
    for (int k = 3; k <= 6; k++) drive(1, 16'(k * 100), 1'b1);
    drive(1, 16'd0, 1'b0);
    idle(10);

    // 8-bit modular wrap: 120 then -126.
    drive(2, 16'd120, 1'b1);
    drive(2, 16'hFF82, 1'b1);
    drive(2, 16'd0, 1'b0);
    idle(6);

    // Sparse strobes every third cycle, R=2, M=2.
    for (int k = 0; k < 12; k++) begin
      drive(3, 16'(k * 7 - 30), 1'b1);
      drive(3, 16'd0, 1'b0);
      drive(3, 16'd0, 1'b0);
    end
    idle(8);

    // 16->12 bits: comb outputs 24, 32767, -40, 8.
    drive(4, 16'd24, 1'b1);
    drive(4, 16'h8017, 1'b1);
    drive(4, 16'h7FEF, 1'b1);
    drive(4, 16'h7FF7, 1'b1);
    drive(4, 16'd0, 1'b0);
    idle(6);

    done = 1'b1;
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
